// File: rtl/difftest_int_wb_arbiter.sv
// difftest_int_wb_arbiter
//
// Shares one difftest integer-writeback reporting port between NUM_PORTS
// commit-stage requesters. A round-robin arbiter grants at most one
// requester per cycle. Granted writes to x0 are consumed and dropped. All
// other granted events go into a DEPTH-entry show-ahead FIFO. The FIFO head
// drives the sink through a valid/ready handshake. Events from one port
// leave in acceptance order, and events from different ports leave in
// grant order.
//
// Parameters:
//   NUM_PORTS  number of requesters (1..8)
//   DEPTH      FIFO entries (power of two, >= 2)
//   CORE_ID    constant driven on out_coreid
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   flush           synchronous FIFO clear (pipeline redirect)
//   in_valid        per-port request
//   in_address      5 bits per port, port i at [5i+4:5i]
//   in_data         64 bits per port, port i at [64i+63:64i]
//   in_ready        one-hot (or zero) grant
//   out_valid       FIFO head valid
//   out_ready       sink accepts the head
//   out_address     head address, zero when out_valid is low
//   out_data        head data, zero when out_valid is low
//   out_coreid      constant CORE_ID
//
// Optional build macro DIFFTEST_WB_STATS_EN adds three 32-bit counters:
//   stat_accepted    non-x0 enqueues
//   stat_x0_dropped  x0 transfers that were filtered out
//   stat_full_stall  cycles with any request while the FIFO is full
// The counters clear on reset and wrap. Flush does not clear them.

module difftest_int_wb_arbiter #(
    parameter int         NUM_PORTS = 2,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] CORE_ID   = 8'd0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_PORTS-1:0]      in_valid,
    input  logic [5*NUM_PORTS-1:0]    in_address,
    input  logic [64*NUM_PORTS-1:0]   in_data,
    output logic [NUM_PORTS-1:0]      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4:0]                out_address,
    output logic [63:0]               out_data,
    output logic [7:0]                out_coreid
`ifdef DIFFTEST_WB_STATS_EN
    ,
    output logic [31:0]               stat_accepted,
    output logic [31:0]               stat_x0_dropped,
    output logic [31:0]               stat_full_stall
`endif
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // FIFO storage and pointers
    logic [4:0]    mem_addr [DEPTH];
    logic [63:0]   mem_data [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [PW-1:0] rr;

    // Arbitration
    logic          found;
    logic [PW-1:0] grant_idx;
    int            cand;
    logic [4:0]    sel_addr;
    logic [63:0]   sel_data;
    logic          full;
    logic          can_accept;
    logic          xfer;
    logic          enq;
    logic          deq;
    logic [PW-1:0] rr_next;

    assign full       = (count == CW'(DEPTH));
    // The grant never looks at out_ready. A pop in the same cycle does not
    // open a slot for a new event while the FIFO is full.
    assign can_accept = !full && !flush;

    // Search rr, rr+1, ... with wrap. The first requester found wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            cand = (int'(rr) + off) % NUM_PORTS;
            if (!found && in_valid[cand]) begin
                found     = 1'b1;
                grant_idx = PW'(cand);
            end
        end
    end

    always_comb begin
        sel_addr = in_address[int'(grant_idx)*5 +: 5];
        sel_data = in_data[int'(grant_idx)*64 +: 64];
    end

    always_comb begin
        in_ready = '0;
        if (found && can_accept) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer    = found && can_accept;
    // An x0 transfer still completes, so the requester sees ready and rr
    // advances. Only the FIFO write is suppressed.
    assign enq     = xfer && (sel_addr != 5'd0);
    // The head is still shown during flush, but the pop is ignored.
    assign deq     = out_valid && out_ready && !flush;
    assign rr_next = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rr    <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (xfer) begin
                rr <= rr_next;
            end
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The payload RAM needs no reset. Pointers and count decide what is valid.
    always_ff @(posedge clock) begin
        if (enq && !reset) begin
            mem_addr[tail] <= sel_addr;
            mem_data[tail] <= sel_data;
        end
    end

    assign out_valid   = (count != '0);
    assign out_address = out_valid ? mem_addr[head] : 5'd0;
    assign out_data    = out_valid ? mem_data[head] : 64'd0;
    assign out_coreid  = CORE_ID;

`ifdef DIFFTEST_WB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_accepted   <= '0;
            stat_x0_dropped <= '0;
            stat_full_stall <= '0;
        end else begin
            if (enq) begin
                stat_accepted <= stat_accepted + 32'd1;
            end
            if (xfer && (sel_addr == 5'd0)) begin
                stat_x0_dropped <= stat_x0_dropped + 32'd1;
            end
            if ((|in_valid) && full) begin
                stat_full_stall <= stat_full_stall + 32'd1;
            end
        end
    end
`endif

    count_bounded: assert property (@(posedge clock) disable iff (reset) count <= CW'(DEPTH));

endmodule

// File: tb/tb_difftest_int_wb_arbiter.sv
// Testbench for difftest_int_wb_arbiter with NUM_PORTS=2, DEPTH=8.
// Inputs are applied one cycle at a time. The combinational outputs
// (in_ready and the FIFO head) are compared against hand-computed values
// at the falling edge, before the rising edge commits the cycle.

module tb_difftest_int_wb_arbiter;

    localparam int         NP   = 2;
    localparam int         DP   = 8;
    localparam logic [7:0] CID  = 8'h5A;

    logic          clock;
    logic          reset;
    logic          flush;
    logic [NP-1:0] in_valid;
    logic [5*NP-1:0]  in_address;
    logic [64*NP-1:0] in_data;
    logic [NP-1:0] in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    out_address;
    logic [63:0]   out_data;
    logic [7:0]    out_coreid;
`ifdef DIFFTEST_WB_STATS_EN
    logic [31:0]   stat_accepted;
    logic [31:0]   stat_x0_dropped;
    logic [31:0]   stat_full_stall;
`endif

    difftest_int_wb_arbiter #(.NUM_PORTS(NP), .DEPTH(DP), .CORE_ID(CID)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_address(in_address),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_address(out_address),
        .out_data(out_data),
        .out_coreid(out_coreid)
`ifdef DIFFTEST_WB_STATS_EN
        ,
        .stat_accepted(stat_accepted),
        .stat_x0_dropped(stat_x0_dropped),
        .stat_full_stall(stat_full_stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        fl;
        logic [1:0]  v;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic        ordy;
        logic [1:0]  e_rdy;
        logic        e_ov;
        logic [4:0]  e_oa;
        logic [63:0] e_od;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic rst, input logic fl, input logic [1:0] v,
                                input logic [4:0] a0, input logic [63:0] d0,
                                input logic [4:0] a1, input logic [63:0] d1,
                                input logic ordy, input logic [1:0] e_rdy,
                                input logic e_ov, input logic [4:0] e_oa,
                                input logic [63:0] e_od);
        vec_t t;
        t.rst = rst; t.fl = fl; t.v = v; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
        t.ordy = ordy; t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_oa = e_oa; t.e_od = e_od;
        return t;
    endfunction

    function automatic void add(input logic rst, input logic fl, input logic [1:0] v,
                                input logic [4:0] a0, input logic [63:0] d0,
                                input logic [4:0] a1, input logic [63:0] d1,
                                input logic ordy, input logic [1:0] e_rdy,
                                input logic e_ov, input logic [4:0] e_oa,
                                input logic [63:0] e_od);
        vecs.push_back(mk(rst, fl, v, a0, d0, a1, d1, ordy, e_rdy, e_ov, e_oa, e_od));
    endfunction

    task automatic apply(input vec_t t, input int id);
        reset      = t.rst;
        flush      = t.fl;
        in_valid   = t.v;
        in_address = {t.a1, t.a0};
        in_data    = {t.d1, t.d0};
        out_ready  = t.ordy;
        @(negedge clock);
        n_vec++;
        if (in_ready !== t.e_rdy || out_valid !== t.e_ov ||
            out_address !== t.e_oa || out_data !== t.e_od) begin
            n_miss++;
            $display("FAIL vec%0d: got rdy=%b ov=%b addr=%0d data=%h, want rdy=%b ov=%b addr=%0d data=%h",
                     id, in_ready, out_valid, out_address, out_data,
                     t.e_rdy, t.e_ov, t.e_oa, t.e_od);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int split;
        int budget;

        reset = 1'b1; flush = 1'b0; in_valid = '0; in_address = '0; in_data = '0; out_ready = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        n_vec++;
        if (out_coreid !== CID) begin
            n_miss++;
            $display("FAIL coreid: got %h, want %h", out_coreid, CID);
        end

        // idle after reset
        add(0,0,2'b00, 0,64'h0, 0,64'h0, 1, 2'b00, 0, 0, 64'h0);
        // both ports request each cycle: grants alternate, output lags by one
        add(0,0,2'b11, 1,64'h11, 2,64'h22, 1, 2'b01, 0, 0, 64'h0);
        add(0,0,2'b11, 1,64'h11, 2,64'h22, 1, 2'b10, 1, 1, 64'h11);
        add(0,0,2'b11, 1,64'h11, 2,64'h22, 1, 2'b01, 1, 2, 64'h22);
        add(0,0,2'b11, 1,64'h11, 2,64'h22, 1, 2'b10, 1, 1, 64'h11);
        add(0,0,2'b00, 0,64'h0,  0,64'h0,  1, 2'b00, 1, 2, 64'h22);
        add(0,0,2'b00, 0,64'h0,  0,64'h0,  1, 2'b00, 0, 0, 64'h0);
        // x0 is consumed but never reaches the output
        add(0,0,2'b01, 0,64'hDEAD, 0,64'h0, 1, 2'b01, 0, 0, 64'h0);
        add(0,0,2'b01, 5,64'h1234, 0,64'h0, 1, 2'b01, 0, 0, 64'h0);
        add(0,0,2'b00, 0,64'h0,    0,64'h0, 1, 2'b00, 1, 5, 64'h1234);
        add(0,0,2'b00, 0,64'h0,    0,64'h0, 1, 2'b00, 0, 0, 64'h0);
        // fill to DEPTH with out_ready=0, then the 9th request waits
        for (int k = 1; k <= DP; k++) begin
            add(0,0,2'b10, 0,64'h0, 5'(k), 64'(k*256), 0, 2'b10,
                (k != 1), (k != 1) ? 5'd1 : 5'd0, (k != 1) ? 64'h100 : 64'h0);
        end
        add(0,0,2'b10, 0,64'h0, 9,64'h900, 0, 2'b00, 1, 1, 64'h100);
        // full plus a pop in the same cycle: still no grant
        add(0,0,2'b10, 0,64'h0, 9,64'h900, 1, 2'b00, 1, 1, 64'h100);
        add(0,0,2'b10, 0,64'h0, 9,64'h900, 1, 2'b10, 1, 2, 64'h200);
        for (int k = 3; k <= 9; k++) begin
            add(0,0,2'b00, 0,64'h0, 0,64'h0, 1, 2'b00, 1, 5'(k), 64'(k*256));
        end
        add(0,0,2'b00, 0,64'h0, 0,64'h0, 1, 2'b00, 0, 0, 64'h0);
        // four queued, then flush
        for (int k = 0; k < 4; k++) begin
            add(0,0,2'b01, 5'(10+k), 64'(160+k), 0,64'h0, 0, 2'b01,
                (k != 0), (k != 0) ? 5'd10 : 5'd0, (k != 0) ? 64'd160 : 64'd0);
        end
        add(0,1,2'b01, 20,64'hB0, 0,64'h0, 1, 2'b00, 1, 10, 64'd160);
        add(0,0,2'b01, 20,64'hB0, 0,64'h0, 1, 2'b01, 0, 0, 64'h0);
        add(0,0,2'b00, 0,64'h0,   0,64'h0, 1, 2'b00, 1, 20, 64'hB0);
        add(0,0,2'b00, 0,64'h0,   0,64'h0, 1, 2'b00, 0, 0, 64'h0);
        split = vecs.size();
        // three queued, reset with requests pending
        for (int k = 0; k < 3; k++) begin
            add(0,0,2'b01, 5'(21+k), 64'(33+k), 0,64'h0, 0, 2'b01,
                (k != 0), (k != 0) ? 5'd21 : 5'd0, (k != 0) ? 64'd33 : 64'd0);
        end
        add(1,0,2'b11, 24,64'h24, 25,64'h25, 1, 2'b10, 1, 21, 64'd33);
        add(0,0,2'b11, 24,64'h24, 25,64'h25, 1, 2'b01, 0, 0, 64'h0);
        add(0,0,2'b00, 0,64'h0,   0,64'h0,   1, 2'b00, 1, 24, 64'h24);
        add(0,0,2'b00, 0,64'h0,   0,64'h0,   1, 2'b00, 0, 0, 64'h0);

        for (int i = 0; i < split; i++) apply(vecs[i], i);

`ifdef DIFFTEST_WB_STATS_EN
        n_vec++;
        if (stat_accepted !== 32'd19 || stat_x0_dropped !== 32'd1 || stat_full_stall !== 32'd2) begin
            n_miss++;
            $display("FAIL stats: got acc=%0d x0=%0d stall=%0d, want acc=19 x0=1 stall=2",
                     stat_accepted, stat_x0_dropped, stat_full_stall);
        end
`endif

        for (int i = split; i < vecs.size(); i++) apply(vecs[i], i);

        // head stays stable while out_ready toggles; rr is 1 here
        apply(mk(0,0,2'b10, 0,64'h0, 30,64'h30, 0, 2'b10, 0, 0, 64'h0), 100);
        apply(mk(0,0,2'b01, 31,64'h31, 0,64'h0, 0, 2'b01, 1, 30, 64'h30), 101);
        apply(mk(0,0,2'b00, 0,64'h0, 0,64'h0, 0, 2'b00, 1, 30, 64'h30), 102);
        apply(mk(0,0,2'b00, 0,64'h0, 0,64'h0, 0, 2'b00, 1, 30, 64'h30), 103);
        apply(mk(0,0,2'b00, 0,64'h0, 0,64'h0, 1, 2'b00, 1, 30, 64'h30), 104);
        apply(mk(0,0,2'b00, 0,64'h0, 0,64'h0, 0, 2'b00, 1, 31, 64'h31), 105);

        // drain with a bounded wait
        out_ready = 1'b1;
        budget = 0;
        while (out_valid === 1'b1 && budget < 5) begin
            @(posedge clock);
            #1;
            budget++;
        end
        n_vec++;
        if (out_valid !== 1'b0 || budget != 1) begin
            n_miss++;
            $display("FAIL drain: got ov=%b after %0d cycles, want ov=0 after 1", out_valid, budget);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
